multi_voltage_system: RTL and testbench

Two-mode datapath model of a multi-voltage island: a high-performance (HP) path registers data every cycle, and a low-power (LP) path registers data at a divided rate. A mode FSM sequences voltage ramps with a fixed settle time. During each ramp, isolation holds the output at its last valid value. The block sits between an upstream producer and a downstream consumer, and is steered by a power-management enable.

---
 rtl/multi_voltage_system_pkg.sv | 27 ++
 rtl/multi_voltage_system_lp_rate_enable.sv | 46 ++++
 rtl/multi_voltage_system.sv | 114 +++++++++++
 tb/tb_multi_voltage_system.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/multi_voltage_system_pkg.sv
// Shared definitions for the multi-voltage island model.
//   state_t          : mode FSM encoding (LP, RAMP_UP, HP, RAMP_DOWN)
//   DEFAULT_*        : default parameter values for the top module
//   cnt_width()      : counter width for a modulo-n counter, at least 1 bit
package multi_voltage_system_pkg;

  typedef enum logic [1:0] {
    ST_LP        = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HP        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_LP_DIV        = 2;
  localparam int DEFAULT_SETTLE_CYCLES = 2;

  // Bits needed to count 0..n-1; a modulo-1 counter still gets one bit so
  // that every counter is a real signal.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage : multi_voltage_system_pkg

// File: rtl/multi_voltage_system_lp_rate_enable.sv
// Modulo-LP_DIV sample-rate counter for the low-power path.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset (count -> 0)
//   run    : advance the count on this edge
//   clear  : force the count to 0 on this edge (wins over run)
//   tick   : high during the cycle in which run=1 and count==LP_DIV-1,
//            i.e. the edge that ends this cycle is an LP sample edge
module lp_rate_enable
  import multi_voltage_system_pkg::*;
#(
  parameter int LP_DIV = DEFAULT_LP_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(LP_DIV);
  localparam logic [CW-1:0] LAST = CW'(LP_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          at_last;

  assign at_last = (div_cnt == LAST);
  assign tick    = run && at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      // Wrap explicitly at LP_DIV-1 so non-power-of-two dividers never
      // visit counts outside 0..LP_DIV-1.
      if (at_last) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

endmodule : lp_rate_enable

// File: rtl/multi_voltage_system.sv
// Two-mode datapath of a multi-voltage island.
// HP mode registers data_in every cycle; LP mode registers it once every
// LP_DIV cycles. Mode changes go through a fixed SETTLE_CYCLES ramp during
// which the output is clamped to its last value (isolation).
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   high_perf_en : 1 requests HP mode, 0 requests LP mode
//   data_in      : input data
//   data_out     : registered output data
module multi_voltage_system
  import multi_voltage_system_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int LP_DIV        = DEFAULT_LP_DIV,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             high_perf_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam int RW = cnt_width(SETTLE_CYCLES);
  localparam logic [RW-1:0] RAMP_LAST = RW'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [RW-1:0]    ramp_cnt;
  logic [RW-1:0]    ramp_cnt_next;
  logic [WIDTH-1:0] data_next;
  logic             lp_tick;

  // The divider only runs while in LP and sits at 0 everywhere else, so
  // every LP entry starts a fresh sample period. On the LP->RAMP_UP edge it
  // still advances once (the LP capture rule applies on that edge), then
  // the clear takes over during the ramp.
  lp_rate_enable #(
    .LP_DIV (LP_DIV)
  ) u_lp_rate_enable (
    .clk   (clk),
    .reset (reset),
    .run   (state == ST_LP),
    .clear (state != ST_LP),
    .tick  (lp_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_LP;
      ramp_cnt <= '0;
      data_out <= '0;
    end else begin
      state    <= state_next;
      ramp_cnt <= ramp_cnt_next;
      data_out <= data_next;
    end
  end

  always_comb begin
    state_next    = state;
    ramp_cnt_next = ramp_cnt;
    data_next     = data_out;

    unique case (state)
      ST_LP: begin
        if (lp_tick) begin
          data_next = data_in;
        end
        if (high_perf_en) begin
          state_next    = ST_RAMP_UP;
          ramp_cnt_next = '0;
        end
      end

      // Ramps ignore both data_in and the mode request; they always run to
      // completion. The counter returns to 0 on the final edge instead of
      // wrapping past SETTLE_CYCLES-1.
      ST_RAMP_UP: begin
        if (ramp_cnt == RAMP_LAST) begin
          state_next    = ST_HP;
          ramp_cnt_next = '0;
        end else begin
          ramp_cnt_next = ramp_cnt + RW'(1);
        end
      end

      ST_HP: begin
        // Capture even on the edge that leaves HP.
        data_next = data_in;
        if (!high_perf_en) begin
          state_next    = ST_RAMP_DOWN;
          ramp_cnt_next = '0;
        end
      end

      ST_RAMP_DOWN: begin
        if (ramp_cnt == RAMP_LAST) begin
          state_next    = ST_LP;
          ramp_cnt_next = '0;
        end else begin
          ramp_cnt_next = ramp_cnt + RW'(1);
        end
      end

      default: begin
        state_next    = ST_LP;
        ramp_cnt_next = '0;
      end
    endcase
  end

endmodule : multi_voltage_system

// File: tb/tb_multi_voltage_system.sv
// Directed self-checking bench for multi_voltage_system.
// Main instance uses the default parameters (LP_DIV=2, SETTLE_CYCLES=2);
// a second instance with LP_DIV=1, SETTLE_CYCLES=1 covers the boundary
// settings on the first few edges after reset.
module tb_multi_voltage_system;
  import multi_voltage_system_pkg::*;

  logic       clk;
  logic       reset;
  logic       high_perf_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] data_out_fast;

  int n_checks;
  int n_fail;

  multi_voltage_system #(
    .WIDTH         (8),
    .LP_DIV        (2),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .high_perf_en (high_perf_en),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  multi_voltage_system #(
    .WIDTH         (8),
    .LP_DIV        (1),
    .SETTLE_CYCLES (1)
  ) dut_fast (
    .clk          (clk),
    .reset        (reset),
    .high_perf_en (high_perf_en),
    .data_in      (data_in),
    .data_out     (data_out_fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, observed, expected);
    end else begin
      $display("ok   %s: %02h", tag, observed);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive data_in, take one edge, compare data_out.
  task automatic cyc(input string tag, input logic [7:0] din,
                     input logic [7:0] exp_out);
    data_in = din;
    step();
    check(tag, data_out, exp_out);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    high_perf_en = 1'b0;
    data_in      = 8'hFF;

    // Reset held across several edges.
    repeat (3) step();
    check("rst_dout", data_out, 8'h00);
    check("rst_state", 8'(dut.state), 8'(ST_LP));
    check("rst_dout_fast", data_out_fast, 8'h00);

    // LP rate after reset release.
    reset = 1'b1;
    cyc("lp_e1", 8'hA5, 8'h00);
    check("fast_e1", data_out_fast, 8'hA5);
    cyc("lp_e2", 8'hA5, 8'hA5);
    cyc("lp_e3", 8'h3C, 8'hA5);
    check("fast_e3", data_out_fast, 8'h3C);
    cyc("lp_e4", 8'h3C, 8'h3C);

    // Ramp up from LP (divider at 0, so the request edge does not capture
    // in the LP_DIV=2 instance, but does in the LP_DIV=1 instance).
    high_perf_en = 1'b1;
    cyc("up_req", 8'h44, 8'h3C);
    check("up_state", 8'(dut.state), 8'(ST_RAMP_UP));
    check("fast_up_req", data_out_fast, 8'h44);
    cyc("up_hold1", 8'h11, 8'h3C);
    check("fast_up_ramp", data_out_fast, 8'h44);
    cyc("up_hold2", 8'h22, 8'h3C);
    check("fast_hp", data_out_fast, 8'h22);
    check("hp_state", 8'(dut.state), 8'(ST_HP));
    cyc("hp_first", 8'h33, 8'h33);
    cyc("hp_follow", 8'h34, 8'h34);

    // HP throughput.
    cyc("hp_01", 8'h01, 8'h01);
    cyc("hp_02", 8'h02, 8'h02);
    cyc("hp_03", 8'h03, 8'h03);

    // Ramp down and LP re-entry.
    high_perf_en = 1'b0;
    cyc("dn_req", 8'h55, 8'h55);
    check("dn_state", 8'(dut.state), 8'(ST_RAMP_DOWN));
    cyc("dn_hold1", 8'h66, 8'h55);
    cyc("dn_hold2", 8'h77, 8'h55);
    check("lp_state", 8'(dut.state), 8'(ST_LP));
    cyc("lp2_e1", 8'h88, 8'h55);
    cyc("lp2_e2", 8'h99, 8'h99);
    cyc("lp2_e3", 8'hAA, 8'h99);
    cyc("lp2_e4", 8'hAA, 8'hAA);

    // Request pulse inside RAMP_UP: ramp completes, one HP edge, ramp down.
    high_perf_en = 1'b1;
    cyc("tog_req", 8'hB1, 8'hAA);
    high_perf_en = 1'b0;
    cyc("tog_ramp1", 8'hB2, 8'hAA);
    cyc("tog_ramp2", 8'hB3, 8'hAA);
    check("tog_hp_state", 8'(dut.state), 8'(ST_HP));
    cyc("tog_hp_cap", 8'hB4, 8'hB4);
    check("tog_dn_state", 8'(dut.state), 8'(ST_RAMP_DOWN));
    cyc("tog_dn1", 8'hB5, 8'hB4);
    cyc("tog_dn2", 8'hB6, 8'hB4);
    check("tog_lp_state", 8'(dut.state), 8'(ST_LP));

    // Asynchronous reset while in HP.
    high_perf_en = 1'b1;
    cyc("ar_req", 8'hC1, 8'hB4);
    cyc("ar_ramp1", 8'hC2, 8'hB4);
    cyc("ar_ramp2", 8'hC3, 8'hB4);
    cyc("ar_hp", 8'hC7, 8'hC7);
    #2;
    reset = 1'b0;
    #1;
    check("ar_dout", data_out, 8'h00);
    check("ar_state", 8'(dut.state), 8'(ST_LP));
    step();
    reset        = 1'b1;
    high_perf_en = 1'b0;
    cyc("ar_rel_e1", 8'hD1, 8'h00);
    cyc("ar_rel_e2", 8'hD2, 8'hD2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_multi_voltage_system
